serial_adder_sched: RTL and testbench
=====================================

Name: serial_adder_sched

Overview:
- Schedules a single 1-bit full-adder cell (the team's FullAdder) to perform WIDTH-bit additions bit-serially, LSB first.
- Two requester ports share the cell under round-robin arbitration with valid/ready handshakes.
- Results return on one output port with valid/ready back-pressure, tagged with the requester ID.
- Sits between the tt_um top-level I/O glue and the full-adder datapath.

Parameters:
WIDTH, 8, operand and sum width in bits (must be 2 or more).
CNT_W, $clog2(WIDTH), width of the bit-index counter.

Ports:
clk  in  1  system clock; all logic on the rising edge
rst_n  in  1  reset; synchronous, active-low
req_valid  in  2  per-port request valid; bit 0 is port 0, bit 1 is port 1
req_ready  out  2  per-port accept strobe; at most one bit high, only in IDLE
req_a  in  2*WIDTH  operand A per port; port 0 is [WIDTH-1:0]
req_b  in  2*WIDTH  operand B per port, same packing as req_a
req_cin  in  2  carry-in per port
res_valid  out  1  result available
res_ready  in  1  result consumer ready
res_sum  out  WIDTH  sum, modulo 2^WIDTH
res_cout  out  1  carry out of the MSB
res_id  out  1  port that issued this result
busy  out  1  high in RUN or DONE

Behaviour:
- Reset (rst_n=0 at a rising clk edge) forces:
  - state=IDLE, rr_ptr=0 (port 0 preferred).
  - res_valid=0, res_sum=0, res_cout=0, res_id=0, busy=0.
  - Bit counter=0, carry register=0, operand shift registers=0.
  - req_ready=0 while rst_n is low.
  - Reset mid-RUN or mid-DONE aborts the operation; no result is ever presented.
- States: IDLE, RUN, DONE.
- IDLE:
  - req_ready is combinational: grant = the single valid port if only one is valid; if both are valid, the port indexed by rr_ptr.
  - Transfer occurs when req_valid[g] & req_ready[g].
  - On transfer: latch the port's A, B and cin into the shift registers and carry register; record grant into id_reg; clear the counter; go to RUN.
  - No valid request: stay in IDLE, req_ready=0.
- RUN: exactly WIDTH cycles.
  - Each cycle the cell computes sum = a[0]^b[0]^carry and cout = (a[0]^b[0])&carry | a[0]&b[0].
  - Register carry<=cout.
  - Shift A and B right by 1.
  - Shift the sum bit into the result register from the MSB side, so after WIDTH shifts bit i sits at position i.
  - When counter==WIDTH-1: go to DONE; counter returns to 0.
- DONE:
  - res_valid=1; res_sum, res_cout (final carry) and res_id=id_reg are stable.
  - They hold until res_ready=1. On that edge: go to IDLE, rr_ptr<=~id_reg, res_valid<=0.
  - If res_ready is already high in the first DONE cycle, DONE lasts one cycle.
- Outputs outside DONE:
  - res_valid=0.
  - res_sum, res_cout and res_id keep their last values and must not be sampled.
- Latency: transfer at edge T; RUN covers edges T+1..T+WIDTH; res_valid is high in the cycle after edge T+WIDTH.
  - With res_ready held high: result handshakes at edge T+WIDTH+1, and the next transfer is possible at edge T+WIDTH+2.
  - Minimum issue interval is WIDTH+2 cycles.
- Requests during RUN or DONE: req_ready=0. Requesters must hold valid and operands stable until accepted. The block never drops or reorders an accepted request.
- Fairness: after a port is served, the other port wins the next simultaneous contention. A single requester is always granted immediately regardless of rr_ptr.
- Changes to req_* in cycles where req_ready is low have no effect.

Test Plan:
- Reset then port0 A=8'hFF, B=8'h01, cin=0 -> req_ready[0] pulses one cycle; res_valid rises 9 cycles after transfer with res_sum=8'h00, res_cout=1, res_id=0.
- Port1 A=8'h7F, B=8'h80, cin=1 -> res_sum=8'h00, res_cout=1, res_id=1; port1 A=8'h35, B=8'h4A, cin=0 -> res_sum=8'h7F, res_cout=0.
- Both ports valid continuously from reset, res_ready=1 -> grants alternate 0,1,0,1; every transfer exactly 10 cycles apart; res_id alternates in the same order.
- Result back-pressure: res_ready=0 for 5 cycles in DONE -> res_valid, res_sum, res_cout and res_id stay stable; req_ready=0 and busy=1 throughout; IDLE one cycle after res_ready=1.
- rst_n=0 for one cycle at RUN bit 4 -> next cycle IDLE, busy=0, res_valid=0; res_valid never asserts for the aborted request; a fresh port0 request then completes correctly.
- Random 1000 ops per port, random valid and res_ready gaps -> each result equals {cout,sum} = A+B+cin; result order matches grant order; no request is lost or duplicated.

Source files
------------

// File: rtl/serial_adder_sched_if.sv
// Request/result bundle for the bit-serial adder scheduler.
// master: requesters and result consumer; slave: the scheduler.
interface serial_adder_sched_if #(
    parameter int WIDTH = 8
);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [2*WIDTH-1:0] req_a;
    logic [2*WIDTH-1:0] req_b;
    logic [1:0]         req_cin;
    logic               res_valid;
    logic               res_ready;
    logic [WIDTH-1:0]   res_sum;
    logic               res_cout;
    logic               res_id;
    logic               busy;

    modport master (
        output req_valid, req_a, req_b, req_cin, res_ready,
        input  req_ready, res_valid, res_sum, res_cout, res_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, res_ready,
        output req_ready, res_valid, res_sum, res_cout, res_id, busy
    );
endinterface

// File: rtl/serial_adder_sched.sv
// Bit-serial adder scheduler: one full-adder cell shared by two requesters
// under round-robin arbitration, LSB first, one result port tagged with the
// requester id.
module serial_adder_sched #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_adder_sched_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_rr_ptr;
    logic             r_id;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;

    logic             w_grant;
    logic [1:0]       w_req_ready;
    logic             w_xfer;
    logic             w_last;
    logic [1:0]       w_fa;

    // One full-adder cell: returns {cout, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        logic p;
        p = a ^ b;
        return {(p & c) | (a & b), p ^ c};
    endfunction

    assign w_fa   = full_add(r_a[0], r_b[0], r_carry);
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_xfer = |w_req_ready;

    // Arbitration: a lone requester always wins; contention resolved by rr pointer.
    always_comb begin
        w_grant     = 1'b0;
        w_req_ready = 2'b00;
        case (bus.req_valid)
            2'b01:   w_grant = 1'b0;
            2'b10:   w_grant = 1'b1;
            2'b11:   w_grant = r_rr_ptr;
            default: w_grant = 1'b0;
        endcase
        if (rst_n && (r_state == S_IDLE) && (bus.req_valid != 2'b00)) begin
            w_req_ready[w_grant] = 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_xfer)        w_state_nxt = S_RUN;
            S_RUN:   if (w_last)        w_state_nxt = S_DONE;
            S_DONE:  if (bus.res_ready) w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture, serial add/shift and round-robin pointer update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr <= 1'b0;
            r_id     <= 1'b0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_sum    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        r_a     <= w_grant ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
                        r_b     <= w_grant ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
                        r_carry <= bus.req_cin[w_grant];
                        r_id    <= w_grant;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    // Sum bits enter from the MSB so bit i lands at position i after WIDTH shifts.
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_sum   <= {w_fa[0], r_sum[WIDTH-1:1]};
                    r_carry <= w_fa[1];
                    r_cnt   <= w_last ? '0 : r_cnt + CNT_W'(1);
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        r_rr_ptr <= ~r_id;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.res_valid = (r_state == S_DONE);
    assign bus.res_sum   = r_sum;
    assign bus.res_cout  = r_carry;
    assign bus.res_id    = r_id;
    assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_adder_sched.sv
// Bench for serial_adder_sched: a cycle model of the scheduler checks the
// handshakes every cycle and a queue scoreboard checks each result, while
// scenario tasks check latency, arbitration, back-pressure and reset abort.
module tb_serial_adder_sched;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    logic v0, v1, c0, c1;
    logic [W-1:0] a0, a1, b0, b1;
    logic res_ready;
    int cyc;
    int n_vec;
    int n_err;
    int n_push;
    int n_pop;

    logic [W+1:0] sb[$];

    serial_adder_sched_if #(.WIDTH(W)) bus ();

    assign bus.req_valid = {v1, v0};
    assign bus.req_a     = {a1, a0};
    assign bus.req_b     = {b1, b0};
    assign bus.req_cin   = {c1, c0};
    assign bus.res_ready = res_ready;

    serial_adder_sched #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Cycle model: decides each negedge what the DUT must show and do at the next edge.
    initial begin
        int       m_st;
        int       m_cnt;
        logic     m_rr;
        logic     m_id;
        logic     g;
        logic [1:0] exp_rdy;
        logic [W:0] s;
        logic [W+1:0] e;
        logic [W-1:0] oa, ob;
        logic oc;
        m_st = 0; m_cnt = 0; m_rr = 1'b0; m_id = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                n_vec++;
                if (bus.req_ready !== 2'b00) begin
                    n_err++;
                    $display("FAIL rst_ready: got %b want 00", bus.req_ready);
                end
                m_st = 0; m_cnt = 0; m_rr = 1'b0;
                sb.delete();
            end else begin
                n_vec++;
                if (bus.res_valid !== (m_st == 2)) begin
                    n_err++;
                    $display("FAIL res_valid @%0d: got %b want %b", cyc, bus.res_valid, (m_st == 2));
                end
                n_vec++;
                if (bus.busy !== (m_st != 0)) begin
                    n_err++;
                    $display("FAIL busy @%0d: got %b want %b", cyc, bus.busy, (m_st != 0));
                end
                exp_rdy = 2'b00;
                g = 1'b0;
                if (m_st == 0 && bus.req_valid != 2'b00) begin
                    g = (bus.req_valid == 2'b11) ? m_rr : bus.req_valid[1];
                    exp_rdy[g] = 1'b1;
                end
                n_vec++;
                if (bus.req_ready !== exp_rdy) begin
                    n_err++;
                    $display("FAIL req_ready @%0d: got %b want %b", cyc, bus.req_ready, exp_rdy);
                end
                case (m_st)
                    0: if (exp_rdy != 2'b00) begin
                        oa = g ? a1 : a0;
                        ob = g ? b1 : b0;
                        oc = g ? c1 : c0;
                        s = {1'b0, oa} + {1'b0, ob} + (W+1)'(oc);
                        sb.push_back({g, s});
                        n_push++;
                        m_id = g; m_st = 1; m_cnt = 0;
                    end
                    1: if (m_cnt == W - 1) m_st = 2; else m_cnt++;
                    2: if (res_ready) begin
                        n_vec++;
                        n_pop++;
                        if (sb.size() == 0) begin
                            n_err++;
                            $display("FAIL sb_empty @%0d: got result %h want none", cyc, {bus.res_id, bus.res_cout, bus.res_sum});
                        end else begin
                            e = sb.pop_front();
                            if ({bus.res_id, bus.res_cout, bus.res_sum} !== e) begin
                                n_err++;
                                $display("FAIL result @%0d: got id/cout/sum %h want %h", cyc, {bus.res_id, bus.res_cout, bus.res_sum}, e);
                            end
                        end
                        m_st = 0; m_rr = ~m_id;
                    end
                    default: m_st = 0;
                endcase
            end
            if (n_err >= 200) begin
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
                $finish;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int p, input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        if (p == 0) begin v0 = v; a0 = a; b0 = b; c0 = c; end
        else        begin v1 = v; a1 = a; b1 = b; c1 = c; end
    endtask

    task automatic drop_req(input int p);
        if (p == 0) v0 = 1'b0; else v1 = 1'b0;
    endtask

    // Raise a request, wait for its accept, drop valid after the transfer edge.
    task automatic issue(input int p, input logic [W-1:0] a, input logic [W-1:0] b, input logic c, output int t);
        @(posedge clk); #1;
        set_req(p, 1'b1, a, b, c);
        t = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.req_ready[p]) begin t = cyc; break; end
        end
        n_vec++;
        if (t < 0) begin
            n_err++;
            $display("FAIL accept_timeout port%0d: got no req_ready want accept", p);
        end
        @(posedge clk); #1;
        drop_req(p);
    endtask

    task automatic wait_result(output int t);
        t = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.res_valid) begin t = cyc; break; end
        end
        n_vec++;
        if (t < 0) begin
            n_err++;
            $display("FAIL result_timeout: got no res_valid want result");
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; v1 = 1'b0; res_ready = 1'b0;
        set_req(0, 1'b1, 8'h12, 8'h34, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({bus.res_valid, bus.busy, bus.req_ready, bus.res_id, bus.res_cout} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got valid/busy/ready/id/cout %b%b%b%b%b want 0", bus.res_valid, bus.busy, bus.req_ready, bus.res_id, bus.res_cout);
        end
        n_vec++;
        if (bus.res_sum !== 8'h00) begin
            n_err++;
            $display("FAIL reset_sum: got %h want 00", bus.res_sum);
        end
        @(posedge clk); #1;
        drop_req(0);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int t0, t1;
        @(posedge clk); #1;
        res_ready = 1'b1;
        issue(0, 8'hFF, 8'h01, 1'b0, t0);
        wait_result(t1);
        n_vec++;
        if (t1 - t0 != 9) begin
            n_err++;
            $display("FAIL latency: got %0d want 9", t1 - t0);
        end
        n_vec++;
        if ({bus.res_id, bus.res_cout, bus.res_sum} !== {1'b0, 1'b1, 8'h00}) begin
            n_err++;
            $display("FAIL basic_ff01: got %h want 100", {bus.res_id, bus.res_cout, bus.res_sum});
        end
        issue(1, 8'h7F, 8'h80, 1'b1, t0);
        wait_result(t1);
        n_vec++;
        if ({bus.res_id, bus.res_cout, bus.res_sum} !== {1'b1, 1'b1, 8'h00}) begin
            n_err++;
            $display("FAIL basic_7f80: got %h want 300", {bus.res_id, bus.res_cout, bus.res_sum});
        end
        issue(1, 8'h35, 8'h4A, 1'b0, t0);
        wait_result(t1);
        n_vec++;
        if ({bus.res_id, bus.res_cout, bus.res_sum} !== {1'b1, 1'b0, 8'h7F}) begin
            n_err++;
            $display("FAIL basic_354a: got %h want 27f", {bus.res_id, bus.res_cout, bus.res_sum});
        end
    endtask

    task automatic test_back_to_back;
        int gcyc[4];
        logic gid[4];
        int n;
        int t;
        @(posedge clk); #1;
        rst_n = 1'b0;
        res_ready = 1'b1;
        set_req(0, 1'b1, 8'h11, 8'h22, 1'b0);
        set_req(1, 1'b1, 8'h33, 8'h44, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 80 && n < 4; i++) begin
            @(negedge clk);
            if (bus.req_ready != 2'b00) begin
                gid[n] = bus.req_ready[1];
                gcyc[n] = cyc;
                n++;
            end
        end
        @(posedge clk); #1;
        drop_req(0);
        drop_req(1);
        n_vec++;
        if (n != 4) begin
            n_err++;
            $display("FAIL rr_count: got %0d grants want 4", n);
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_vec++;
                if (gid[k] !== k[0]) begin
                    n_err++;
                    $display("FAIL rr_order[%0d]: got port%0d want port%0d", k, gid[k], k[0]);
                end
            end
            for (int k = 1; k < 4; k++) begin
                n_vec++;
                if (gcyc[k] - gcyc[k-1] != 10) begin
                    n_err++;
                    $display("FAIL rr_interval[%0d]: got %0d want 10", k, gcyc[k] - gcyc[k-1]);
                end
            end
        end
        wait_result(t);
    endtask

    task automatic test_backpressure;
        int t0, t1;
        logic [W+1:0] held;
        @(posedge clk); #1;
        res_ready = 1'b0;
        issue(1, 8'h5A, 8'h3C, 1'b1, t0);
        wait_result(t1);
        held = {bus.res_id, bus.res_cout, bus.res_sum};
        n_vec++;
        if (held !== {1'b1, 1'b0, 8'h97}) begin
            n_err++;
            $display("FAIL bp_value: got %h want 297", held);
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (k == 0) set_req(0, 1'b1, 8'h01, 8'h02, 1'b0);
            @(negedge clk);
            n_vec++;
            if ({bus.res_valid, bus.busy, bus.req_ready} !== 4'b1100 ||
                {bus.res_id, bus.res_cout, bus.res_sum} !== held) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got valid/busy/ready %b%b%b data %h want 1100 data %h",
                         k, bus.res_valid, bus.busy, bus.req_ready, {bus.res_id, bus.res_cout, bus.res_sum}, held);
            end
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({bus.res_valid, bus.busy, bus.req_ready} !== 4'b0001) begin
            n_err++;
            $display("FAIL bp_release: got valid/busy/ready %b%b%b want 0001", bus.res_valid, bus.busy, bus.req_ready);
        end
        @(posedge clk); #1;
        drop_req(0);
        wait_result(t1);
        n_vec++;
        if ({bus.res_id, bus.res_cout, bus.res_sum} !== {1'b0, 1'b0, 8'h03}) begin
            n_err++;
            $display("FAIL bp_next: got %h want 003", {bus.res_id, bus.res_cout, bus.res_sum});
        end
    endtask

    task automatic test_reset_abort;
        int t0, t1;
        @(posedge clk); #1;
        res_ready = 1'b1;
        issue(0, 8'hAA, 8'h55, 1'b1, t0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({bus.res_valid, bus.busy} !== 2'b00) begin
            n_err++;
            $display("FAIL abort_idle: got valid/busy %b%b want 00", bus.res_valid, bus.busy);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            n_vec++;
            if (bus.res_valid !== 1'b0) begin
                n_err++;
                $display("FAIL abort_ghost[%0d]: got res_valid %b want 0", k, bus.res_valid);
            end
        end
        issue(0, 8'h12, 8'h34, 1'b1, t0);
        wait_result(t1);
        n_vec++;
        if ({bus.res_id, bus.res_cout, bus.res_sum, 8'(t1 - t0)} !== {1'b0, 1'b0, 8'h47, 8'd9}) begin
            n_err++;
            $display("FAIL abort_fresh: got id/cout/sum %h lat %0d want 047 lat 9",
                     {bus.res_id, bus.res_cout, bus.res_sum}, t1 - t0);
        end
    endtask

    task automatic rand_req(input int p);
        int gap;
        int ok;
        for (int k = 0; k < 1000; k++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) @(posedge clk);
            @(posedge clk); #1;
            set_req(p, 1'b1, W'($urandom), W'($urandom), 1'($urandom));
            ok = 0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (bus.req_ready[p]) begin ok = 1; break; end
            end
            n_vec++;
            if (ok == 0) begin
                n_err++;
                $display("FAIL rand_accept port%0d op%0d: got no accept want accept", p, k);
            end
            @(posedge clk); #1;
            drop_req(p);
        end
    endtask

    task automatic test_random;
        bit rdone;
        int push0, pop0;
        rdone = 1'b0;
        push0 = n_push;
        pop0  = n_pop;
        fork
            begin
                fork
                    rand_req(0);
                    rand_req(1);
                join
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk); #1;
                    res_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        @(posedge clk); #1;
        res_ready = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (sb.size() != 0 || (n_push - push0) != 2000 || (n_pop - pop0) != 2000) begin
            n_err++;
            $display("FAIL rand_totals: got pending %0d pushed %0d popped %0d want 0/2000/2000",
                     sb.size(), n_push - push0, n_pop - pop0);
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0; n_push = 0; n_pop = 0; cyc = 0;
        rst_n = 1'b0; res_ready = 1'b0;
        v0 = 1'b0; v1 = 1'b0; c0 = 1'b0; c1 = 1'b0;
        a0 = '0; a1 = '0; b0 = '0; b1 = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
